// File: rtl/vga_pat_ctrl.sv
// Pattern scheduler: picks which test pattern the pixel generator draws and
// only lets the selection change right after the first pixel of a frame.
module vga_pat_ctrl #(
    parameter int FRAME_HOLD = 60,
    parameter int PAT_NUM    = 4
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       key_next,
    input  logic       key_mode,
    output logic [1:0] pat_sel,
    output logic       pat_update,
    output logic       auto_mode,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        ST_AUTO   = 1'b0,
        ST_MANUAL = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(FRAME_HOLD - 1);
    localparam logic [1:0] PAT_LAST = 2'(PAT_NUM - 1);

    state_t     state_reg, state_next;
    logic [1:0] pat_sel_reg, pat_sel_next;
    logic       pat_update_reg, pat_update_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic       pend_reg, pend_next;
    logic       cond;
    logic       cond_q_reg;
    logic       sof_q_reg;
    logic       advance;

    assign cond = (pix_x == 10'd0) && (pix_y == 10'd0);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= ST_AUTO;
            pat_sel_reg    <= 2'd0;
            pat_update_reg <= 1'b0;
            frame_cnt_reg  <= 8'd0;
            pend_reg       <= 1'b0;
            cond_q_reg     <= 1'b0;
            sof_q_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pat_sel_reg    <= pat_sel_next;
            pat_update_reg <= pat_update_next;
            frame_cnt_reg  <= frame_cnt_next;
            pend_reg       <= pend_next;
            cond_q_reg     <= cond;
            // Rising edge of the origin condition: one pulse per frame.
            sof_q_reg      <= cond & ~cond_q_reg;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pat_sel_next    = pat_sel_reg;
        pat_update_next = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        pend_next       = pend_reg;
        advance         = 1'b0;

        // A mode toggle swallows any coincident key_next or frame start.
        if (key_mode) begin
            state_next     = (state_reg == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            frame_cnt_next = 8'd0;
            pend_next      = 1'b0;
        end else begin
            if (key_next) begin
                pend_next = 1'b1;
            end
            if (sof_q_reg) begin
                if (pend_reg | key_next) begin
                    advance = 1'b1;
                end else if (state_reg == ST_AUTO) begin
                    if (frame_cnt_reg == CNT_LAST) begin
                        advance = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                    end
                end
            end
        end

        if (advance) begin
            pat_sel_next    = (pat_sel_reg == PAT_LAST) ? 2'd0 : pat_sel_reg + 2'd1;
            pat_update_next = 1'b1;
            frame_cnt_next  = 8'd0;
            pend_next       = 1'b0;
        end
    end

    assign pat_sel    = pat_sel_reg;
    assign pat_update = pat_update_reg;
    assign auto_mode  = (state_reg == ST_AUTO);
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: doc/vga_pat_ctrl.md
Name: vga_pat_ctrl

Overview:
- Pattern scheduler for the VGA pixel-generation path.
- Selects which test pattern the downstream pixel generator draws: colour bar, grey ramp, checkerboard or solid fill.
- Runs in two modes: auto-rotate every FRAME_HOLD frames, or manual step on a debounced key pulse.
- All pattern changes are applied only at start of frame, so no frame ever shows mixed patterns; sits between vga_ctrl (pix_x/pix_y) and the pattern generators.

Parameters:
- FRAME_HOLD, 60: frames each pattern is shown in AUTO mode; legal range 1..256.
- PAT_NUM, 4: number of selectable patterns; legal range 2..4; pat_sel wraps PAT_NUM-1 -> 0.

Ports:
- vga_clk  input  1  pixel clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- pix_x  input  10  current pixel column from vga_ctrl; 10'h3FF outside active area.
- pix_y  input  10  current pixel row from vga_ctrl; 10'h3FF outside active area.
- key_next  input  1  one-cycle pulse: request advance to next pattern.
- key_mode  input  1  one-cycle pulse: toggle AUTO/MANUAL.
- pat_sel  output  2  registered pattern index, 0..PAT_NUM-1.
- pat_update  output  1  one-cycle pulse on the cycle pat_sel takes a new value.
- auto_mode  output  1  1 = AUTO state, 0 = MANUAL state.
- frame_cnt  output  8  frames elapsed on current pattern (AUTO); held at 0 in MANUAL.

Behaviour:
- Reset values (async, immediate): pat_sel=0, pat_update=0, auto_mode=1 (AUTO), frame_cnt=0, internal pend=0, sof_q=0, cond_q=0.
- SOF detection:
  - cond = (pix_x==0 && pix_y==0); cond_q = cond registered.
  - sof = cond & ~cond_q, registered into sof_q.
  - sof_q is a one-cycle pulse, one cycle after the first pixel of the frame; it fires once per frame even if cond holds several cycles.
- FSM has two states, AUTO and MANUAL.
  - key_mode toggles state on the next edge.
  - A key_mode toggle clears frame_cnt and pend.
  - key_mode does not change pat_sel.
- pend flag:
  - Set by key_next in either state.
  - Cleared when an advance is applied or by key_mode.
  - Multiple key_next pulses before a SOF produce a single advance; there is no queue.
- Advance = pat_sel <= (pat_sel==PAT_NUM-1) ? 0 : pat_sel+1; pat_update=1 in that same cycle, 0 otherwise.
- MANUAL: on sof_q, if (pend | key_next), advance and clear pend; otherwise hold.
- AUTO: on sof_q:
  - if (pend | key_next): advance, frame_cnt<=0, clear pend.
  - else if frame_cnt==FRAME_HOLD-1: advance, frame_cnt<=0.
  - else frame_cnt<=frame_cnt+1.
  - FRAME_HOLD=1: advance on every SOF.
- Latency: first-pixel cycle N -> sof_q at N+1 -> pat_sel/pat_update visible after edge N+2. The generator's blanking margin covers this.
- Simultaneous events:
  - key_mode and key_next in the same cycle: key_mode wins; the key_next is discarded (pend stays 0).
  - key_mode in the same cycle as sof_q: mode toggles, no advance, frame_cnt=0.
  - key_next in the same cycle as sof_q: counts for this SOF (advance now).
- pix_x/pix_y held at 10'h3FF (blanking/idle): no SOF, all state holds.
- Reset asserted mid-frame: all outputs return to reset values immediately; the first SOF after release is the first counted frame.
- frame_cnt never exceeds FRAME_HOLD-1; no other wrap path exists.

Test Plan:
- Reset, FRAME_HOLD=3, PAT_NUM=4: run 12 frames -> pat_sel advances 0->1->2->3->0 at frames 3, 6, 9, 12; each change has exactly one pat_update pulse; frame_cnt cycles 0, 1, 2.
- key_mode pulse then 3 key_next pulses mid-frame -> auto_mode=0; exactly one advance (pat_sel 0->1) at the next SOF; no further change over 5 idle frames.
- MANUAL, key_next on the same cycle as sof_q -> advance at that SOF; pat_update two cycles after the first pixel.
- AUTO with frame_cnt=1, key_next mid-frame -> advance at the next SOF and frame_cnt=0; the next automatic advance comes 3 frames later.
- key_mode and key_next in the same cycle -> mode toggles, pend=0, no advance at the next SOF. key_mode coincident with sof_q -> no advance, frame_cnt=0.
- Reset asserted while pat_sel=2 and frame_cnt=2 -> all outputs at reset values the same cycle; pix held at 10'h3FF for 100 cycles -> no pat_update.
